// File: rtl/ftdi_fifo_responder.sv
// rtl/ftdi_fifo_responder.sv - FT245-style FIFO responder with host-side RX and TX byte FIFOs
//
// Emulates the device side of an FTDI synchronous-style FIFO interface. Bytes pushed by the
// host land in the RX FIFO and are read by the controller with in_ftdi_rd. Bytes written by
// the controller with in_ftdi_wr land in the TX FIFO and are popped by the host.
//
// Optional build macro: FTDI_RESP_LOOPBACK_EN - captured write bytes go into the RX FIFO,
// the TX FIFO is removed and the host push/pop side is disabled.
//
// Ports:
//   in_clk, in_rst        clock, asynchronous active-high reset
//   in_ftdi_rd/wr         controller read/write strobes (synchronous to in_clk)
//   io_ftdi_data          shared 8-bit bus, driven only while a read is active
//   out_ftdi_rxf/txe      byte available to read / space available to write
//   in_host_data/push     RX FIFO push side, out_host_full
//   out_host_data/pop     TX FIFO show-ahead pop side, out_host_empty
//   out_proto_err         sticky protocol-error flag

module ftdi_resp_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Storage is never cleared; an empty FIFO presents zero so stale bytes never leak out.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

module ftdi_fifo_responder #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int PRECHARGE = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_ftdi_rd,
  input  logic       in_ftdi_wr,
  inout  wire  [7:0] io_ftdi_data,
  output logic       out_ftdi_rxf,
  output logic       out_ftdi_txe,
  input  logic [7:0] in_host_data,
  input  logic       in_host_push,
  output logic       out_host_full,
  output logic [7:0] out_host_data,
  input  logic       in_host_pop,
  output logic       out_host_empty,
  output logic       out_proto_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACTIVE = 2'd1,
    WR_ACTIVE = 2'd2,
    RECOV     = 2'd3
  } state_t;

  localparam int RC_W = (PRECHARGE > 1) ? $clog2(PRECHARGE) : 1;
  localparam logic [RC_W-1:0] RECOV_LAST = (PRECHARGE > 1) ? RC_W'(PRECHARGE - 1) : '0;

  state_t          state;
  state_t          state_next;
  logic [RC_W-1:0] recov_cnt;
  logic [RC_W-1:0] recov_cnt_next;
  logic            rd_q;
  logic            wr_q;
  logic            proto_err;
  logic            err_set;
  logic            capture;
  logic            rx_fsm_pop;
  logic            cap_full;
  logic            wr_rise;
  logic            rd_fall;

  logic            rx_push;
  logic [7:0]      rx_push_data;
  logic [7:0]      rx_head;
  logic            rx_full;
  logic            rx_empty;

  assign wr_rise = in_ftdi_wr && !wr_q;
  // Inside RD_ACTIVE rd_q is always 1, so this is the strobe's falling edge.
  assign rd_fall = rd_q && !in_ftdi_rd;

  ftdi_resp_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rx_fifo (
    .clk       (in_clk),
    .rst       (in_rst),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_fsm_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

`ifdef FTDI_RESP_LOOPBACK_EN
  logic unused_host;
  assign unused_host    = ^{in_host_data, in_host_push, in_host_pop};
  assign rx_push        = capture;
  assign rx_push_data   = io_ftdi_data;
  assign cap_full       = rx_full;
  assign out_host_full  = rx_full;
  assign out_host_empty = 1'b1;
  assign out_host_data  = 8'h00;
`else
  logic tx_full;
  assign rx_push       = in_host_push;
  assign rx_push_data  = in_host_data;
  assign cap_full      = tx_full;
  assign out_host_full = rx_full;

  ftdi_resp_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tx_fifo (
    .clk       (in_clk),
    .rst       (in_rst),
    .push      (capture),
    .push_data (io_ftdi_data),
    .pop       (in_host_pop),
    .head      (out_host_data),
    .full      (tx_full),
    .empty     (out_host_empty)
  );
`endif

  assign out_ftdi_rxf  = (state == IDLE) && !rx_empty;
  assign out_ftdi_txe  = (state == IDLE) && !cap_full;
  assign out_proto_err = proto_err;

  // Reset is folded in so the bus is released the instant in_rst rises.
  assign io_ftdi_data = ((state == RD_ACTIVE) && !in_rst) ? rx_head : 8'hzz;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state     <= IDLE;
      recov_cnt <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      recov_cnt <= recov_cnt_next;
      rd_q      <= in_ftdi_rd;
      wr_q      <= in_ftdi_wr;
      if (err_set) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    recov_cnt_next = recov_cnt;
    rx_fsm_pop     = 1'b0;
    capture        = 1'b0;
    err_set        = 1'b0;
    case (state)
      IDLE: begin
        // Read wins over write; a colliding write is flagged and otherwise ignored.
        if (in_ftdi_rd) begin
          if (in_ftdi_wr) err_set = 1'b1;
          if (rx_empty) begin
            err_set = 1'b1;
          end else begin
            state_next = RD_ACTIVE;
          end
        end else if (wr_rise) begin
          // A write into a full FIFO still completes the handshake; the byte is dropped.
          capture    = 1'b1;
          if (cap_full) err_set = 1'b1;
          state_next = WR_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (rd_fall) begin
          rx_fsm_pop     = 1'b1;
          state_next     = RECOV;
          recov_cnt_next = '0;
        end
      end
      WR_ACTIVE: begin
        if (!in_ftdi_wr) begin
          state_next     = RECOV;
          recov_cnt_next = '0;
        end
      end
      RECOV: begin
        if (recov_cnt == RECOV_LAST) begin
          state_next = IDLE;
        end else begin
          recov_cnt_next = recov_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// tb/tb_ftdi_fifo_responder.sv - self-checking bench for ftdi_fifo_responder

module tb_ftdi_fifo_responder;

  localparam int DEPTH = 8;
  localparam int PRE   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd = 1'b0, wr = 1'b0, push = 1'b0, pop = 1'b0, boe = 1'b0;
  logic [7:0] hdata = 8'h00, bdata = 8'h00;
  wire  [7:0] bus;
  logic       rxf, txe, hfull, hempty, perr;
  logic [7:0] hout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Undriven bus reads as 8'hFF; RX data in the random run stays below 8'hFF.
  assign bus = boe ? bdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (bus[g]);
  end

  ftdi_fifo_responder #(.DEPTH(DEPTH), .ADDR_W(3), .PRECHARGE(PRE)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_ftdi_rd     (rd),
    .in_ftdi_wr     (wr),
    .io_ftdi_data   (bus),
    .out_ftdi_rxf   (rxf),
    .out_ftdi_txe   (txe),
    .in_host_data   (hdata),
    .in_host_push   (push),
    .out_host_full  (hfull),
    .out_host_data  (hout),
    .in_host_pop    (pop),
    .out_host_empty (hempty),
    .out_proto_err  (perr)
  );

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Reference model: byte queues plus a coarse phase (0 idle, 1 reading, 2 writing, 3 recovery).
  byte unsigned rxq[$];
  byte unsigned txq[$];
  int   m_mode;
  int   m_left;
  logic m_err;
  logic m_wr_prev;
  logic model_on = 1'b0;

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_mode    = 0;
    m_left    = 0;
    m_err     = 1'b0;
    m_wr_prev = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic pu, input logic po,
                            input logic [7:0] hd, input logic [7:0] bd);
    bit rx_pop, tx_push, rx_push_ok, tx_pop_ok;
    rx_pop     = 0;
    tx_push    = 0;
    rx_push_ok = pu && (rxq.size() < DEPTH);
    tx_pop_ok  = po && (txq.size() > 0);
    case (m_mode)
      0: begin
        if (r) begin
          if (w) m_err = 1'b1;
          if (rxq.size() == 0) m_err = 1'b1;
          else m_mode = 1;
        end else if (w && !m_wr_prev) begin
          if (txq.size() < DEPTH) tx_push = 1;
          else m_err = 1'b1;
          m_mode = 2;
        end
      end
      1: if (!r) begin rx_pop = 1; m_mode = 3; m_left = PRE; end
      2: if (!w) begin m_mode = 3; m_left = PRE; end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
    if (rx_pop)     void'(rxq.pop_front());
    if (rx_push_ok) rxq.push_back(hd);
    if (tx_pop_ok)  void'(txq.pop_front());
    if (tx_push)    txq.push_back(bd);
    m_wr_prev = w;
  endtask

  task automatic model_check();
    logic [7:0] e_bus, e_hout;
    e_bus  = (m_mode == 1) ? rxq[0] : 8'hFF;
    e_hout = (txq.size() == 0) ? 8'h00 : txq[0];
    check("model", {rxf, txe, hfull, hempty, perr, hout, bus},
          {(m_mode == 0) && (rxq.size() > 0), (m_mode == 0) && (txq.size() < DEPTH),
           rxq.size() == DEPTH, txq.size() == 0, m_err, e_hout, e_bus});
  endtask

  // One clock: inputs applied now, outputs settled 2 time units after the next rising edge.
  task automatic cyc(input logic r, input logic w, input logic pu, input logic po,
                     input logic [7:0] hd, input logic [7:0] bd);
    rd = r; wr = w; push = pu; pop = po; hdata = hd; bdata = bd;
    boe = w && (m_mode != 1);
    @(posedge clk);
    #1;
    boe = 1'b0;
    if (model_on) model_step(r, w, pu, po, hd, bd);
    #1;
    if (model_on) model_check();
  endtask

  task automatic do_reset();
    rd = 0; wr = 0; push = 0; pop = 0; boe = 0; hdata = 0; bdata = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("reset", {rxf, txe, hfull, hempty, perr, hout, bus},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF});
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  typedef struct packed {
    logic r, w, pu, po;
    logic [7:0] hd, bd;
    logic rxf, txe, full, empty, err;
    logic [7:0] hout, bus;
  } vec_t;

  vec_t tbl [23];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
`ifdef FTDI_RESP_LOOPBACK_EN
    cyc(0, 1, 0, 0, 8'h00, 8'h5A);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    check("lb_rxf", 21'({rxf, hempty}), 21'(2'b11));
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    check("lb_bus", 21'(bus), 21'(8'h5A));
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    check("lb_done", 21'({rxf, txe, hempty, perr}), 21'(4'b0110));
`else
    model_on = 1'b1;
    //            r  w  pu po hd     bd     rxf txe full empty err hout   bus
    tbl[0]  = '{0, 0, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 1, 0, 8'h00, 8'hFF};
    tbl[1]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hA5};
    tbl[2]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hA5};
    tbl[3]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hA5};
    tbl[4]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hA5};
    tbl[5]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hA5};
    tbl[6]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hFF};
    tbl[7]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'hFF};
    tbl[8]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h00, 8'hFF};
    tbl[9]  = '{0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[10] = '{0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[11] = '{0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[12] = '{0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[13] = '{0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[14] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[15] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[16] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h3C, 8'hFF};
    tbl[17] = '{0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1, 0, 8'h00, 8'hFF};
    tbl[18] = '{0, 0, 1, 1, 8'h7E, 8'h00, 1, 1, 0, 1, 0, 8'h00, 8'hFF};
    tbl[19] = '{1, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0, 1, 1, 8'h00, 8'h7E};
    tbl[20] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h00, 8'hFF};
    tbl[21] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h00, 8'hFF};
    tbl[22] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h00, 8'hFF};
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].w, tbl[i].pu, tbl[i].po, tbl[i].hd, tbl[i].bd);
      check($sformatf("tbl[%0d]", i), {rxf, txe, hfull, hempty, perr, hout, bus},
            {tbl[i].rxf, tbl[i].txe, tbl[i].full, tbl[i].empty, tbl[i].err,
             tbl[i].hout, tbl[i].bus});
    end

    // RX FIFO fill, overflow push, in-order reads, then a read from empty.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'(i), 8'h00);
    check("rx_full", 21'({hfull, rxf}), 21'(2'b11));
    cyc(0, 0, 1, 0, 8'h08, 8'h00);
    check("rx_full_push", 21'({hfull, perr}), 21'(2'b10));
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      check("rx_order", 21'(bus), 21'(i));
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    check("rx_empty_rd", 21'({perr, rxf, bus}), 21'({1'b1, 1'b0, 8'hFF}));
    cyc(0, 0, 0, 0, 8'h00, 8'h00);

    // TX FIFO fill, dropped write, host drains exactly the first eight bytes.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 0, 8'h00, (i == 8) ? 8'hFF : 8'(8'h10 + i));
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      if (i == 7) check("tx_full_txe", 21'({txe, perr}), 21'(2'b00));
    end
    check("tx_drop_err", 21'(perr), 21'(1'b1));
    for (int i = 0; i < 8; i++) begin
      check("tx_order", 21'({hempty, hout}), 21'({1'b0, 8'(8'h10 + i)}));
      cyc(0, 0, 0, 1, 8'h00, 8'h00);
    end
    check("tx_drained", 21'({hempty, hout}), 21'({1'b1, 8'h00}));

    // Reset asserted while the bus is being driven.
    do_reset();
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 1, 0, 8'hC3, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 0, 8'h00, 8'h00);
    check("pre_rst_bus", 21'({perr, bus}), 21'({1'b1, 8'hC3}));
    rst = 1'b1;
    #1;
    check("mid_rst", 21'({bus, rxf, hempty, perr}), 21'({8'hFF, 1'b0, 1'b1, 1'b0}));
    model_reset();
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Randomized traffic against the reference model.
    begin
      logic lr, lw;
      lr = 0;
      lw = 0;
      for (int n = 0; n < 1200; n++) begin
        if (n % 300 == 0) begin
          do_reset();
          lr = 0;
          lw = 0;
        end
        if ($urandom_range(0, 3) == 0) lr = ~lr;
        if ($urandom_range(0, 3) == 0) lw = ~lw;
        cyc(lr, lw, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            8'($urandom_range(0, 254)), 8'($urandom));
      end
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_responder.md
FTDI_FIFO_RESPONDER -- requirements
Module: ftdi_fifo_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entries per FIFO, a power of two.
REQ-002 SHALL have parameter ADDR_W, default 3: log2(DEPTH).
REQ-003 SHALL have parameter PRECHARGE, default 2: recovery cycles after each strobe.
REQ-004 SHALL have port in_clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port in_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_ftdi_rd  input  1  active-high read strobe from the FPGA-side controller.
REQ-007 SHALL have port in_ftdi_wr  input  1  active-high write strobe from the controller.
REQ-008 SHALL have port io_ftdi_data  inout  8  shared data bus.
REQ-009 SHALL have port out_ftdi_rxf  output  1  high: a byte is available for the controller to read.
REQ-010 SHALL have port out_ftdi_txe  output  1  high: the controller may write a byte.
REQ-011 SHALL have ports in_host_data  input  8, in_host_push  input  1, out_host_full  output  1: push side of the RX FIFO (bytes bound for the controller).
REQ-012 SHALL have ports out_host_data  output  8, in_host_pop  input  1, out_host_empty  output  1: show-ahead pop side of the TX FIFO (bytes written by the controller).
REQ-013 SHALL have port out_proto_err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL treat the strobes as synchronous to in_clk, with no synchronizers; rd_q and wr_q SHALL be registered copies for edge detection.
REQ-015 SHALL implement states IDLE, RD_ACTIVE, WR_ACTIVE and RECOV.
REQ-016 SHALL drive out_ftdi_rxf = (state==IDLE) && RX FIFO not empty.
REQ-017 SHALL drive out_ftdi_txe = (state==IDLE) && TX FIFO not full.
REQ-018 In IDLE, rd==1 with the RX FIFO not empty SHALL go to RD_ACTIVE; io_ftdi_data SHALL carry the RX head only while in RD_ACTIVE and be high-Z in all other states.
REQ-019 In RD_ACTIVE, rd==0 SHALL pop exactly one RX entry and go to RECOV.
REQ-020 In IDLE, a wr rising edge (wr==1, wr_q==0) SHALL capture io_ftdi_data into the TX FIFO in that same cycle and go to WR_ACTIVE; WR_ACTIVE SHALL go to RECOV when wr==0.
REQ-021 RECOV SHALL last exactly PRECHARGE cycles with rxf=0 and txe=0, then return to IDLE.
REQ-022 rd==1 in IDLE with the RX FIFO empty SHALL set out_proto_err; the state SHALL stay IDLE and the bus SHALL stay high-Z.
REQ-023 A wr rising edge with the TX FIFO full SHALL drop the byte, set out_proto_err and still enter WR_ACTIVE.
REQ-024 rd and wr high together in IDLE: rd SHALL take priority, wr SHALL be ignored and out_proto_err SHALL be set.
REQ-025 Host push when full and host pop when empty SHALL be ignored with no pointer change.
REQ-026 A simultaneous push and pop on the same FIFO SHALL both occur, leaving the occupancy unchanged.
REQ-027 Occupancy counters SHALL be ADDR_W+1 bits wide; pointers SHALL wrap modulo DEPTH.
REQ-028 Worst case, the bus SHALL be driven one clock after rd is sampled high; it SHALL be valid by the controller's sample edge (fourth edge after rd rises).

Reset
REQ-029 in_rst SHALL asynchronously force IDLE, clear all pointers and counters, clear rd_q, wr_q and out_proto_err, and discard FIFO contents.
REQ-030 During and after reset, until the first event: rxf=0, txe=1, out_host_full=0, out_host_empty=1, out_host_data=0, bus high-Z.
REQ-031 Reset asserted mid-transfer SHALL release the bus immediately without waiting for a clock edge.

Configuration
REQ-032 Macro FTDI_RESP_LOOPBACK_EN defined: captured write bytes SHALL be pushed into the RX FIFO instead of the TX FIFO.
REQ-033 With FTDI_RESP_LOOPBACK_EN defined: txe SHALL track RX not-full, in_host_push SHALL be ignored, out_host_full SHALL mirror RX full, out_host_empty SHALL be tied 1 and out_host_data tied 0.
REQ-034 Macro FTDI_RESP_LOOPBACK_EN undefined: behaviour SHALL be exactly as REQ-016 to REQ-026.

Verification
REQ-035 Push 0xA5 via the host port -> rxf=1; rd pulse of 5 cycles -> bus=0xA5 from the 2nd rd cycle; on rd fall, pop occurs, rxf=0 for 2 cycles, then rxf=0 (FIFO empty).
REQ-036 Drive bus 0x3C and raise wr for 5 cycles -> out_host_empty=0 and out_host_data=0x3C; txe low during the strobe plus 2 cycles.
REQ-037 Push 8 bytes 0x00..0x07 -> out_host_full=1; a 9th push is ignored; 8 reads return 0x00..0x07 in order, and a 9th rd sets out_proto_err with the bus high-Z.
REQ-038 Fill the TX FIFO with 8 writes, then write 0xFF -> byte dropped, out_proto_err=1, host pops return only the first 8 bytes.
REQ-039 Assert in_rst while in RD_ACTIVE -> bus high-Z immediately, rxf=0, out_host_empty=1, out_proto_err=0.
REQ-040 With FTDI_RESP_LOOPBACK_EN: write 0x5A -> rxf=1 next IDLE cycle; a read returns 0x5A; out_host_empty stays 1.
